// File: rtl/tap_pulse_generator_if.sv
// Key/tick inputs and tap outputs between the board key, the game tick source
// and the character register.
interface tap_pulse_generator_if;
  logic key_in;
  logic game_tick;
  logic tap;
  logic key_level;
  logic tap_dropped;

  modport master (
    input  key_in,
    input  game_tick,
    output tap,
    output key_level,
    output tap_dropped
  );

  modport slave (
    output key_in,
    output game_tick,
    input  tap,
    input  key_level,
    input  tap_dropped
  );
endinterface

// File: rtl/tap_pulse_generator.sv
// Debounces a raw push-button and emits one game-tick-wide tap per accepted press.
// Define TAP_AUTO_REPEAT_EN to re-fire the press every REPEAT_TICKS ticks while held.
module tap_pulse_generator #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
`ifdef TAP_AUTO_REPEAT_EN
  , parameter int unsigned REPEAT_TICKS  = 8
`endif
) (
  input  logic                  clock,
  input  logic                  resetn,
  tap_pulse_generator_if.master bus
);

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  localparam logic             SYNC_IDLE = KEY_ACTIVE_LOW;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             pressed;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_level_q, key_level_d;
  logic             db_event;
  logic             press_event;
  logic             pending_q, pending_d;
  logic             tap_q, tap_d;
  logic             dropped_q, dropped_d;

`ifdef TAP_AUTO_REPEAT_EN
  localparam int unsigned    RPT_W    = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
  localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_TICKS - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_event;
`endif

  always_comb begin
    sync1_d = bus.key_in;
    sync2_d = sync1_q;
    pressed = KEY_ACTIVE_LOW ? ~sync2_q : sync2_q;
  end

  // Debounce FSM; the counter is shared by the press and release qualification.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    key_level_d = key_level_q;
    db_event    = 1'b0;
    unique case (state_q)
      RELEASED: begin
        if (pressed) begin
          state_d = PRESS_DB;
          cnt_d   = '0;
        end
      end
      PRESS_DB: begin
        if (!pressed) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = HELD;
          cnt_d       = '0;
          key_level_d = 1'b1;
          db_event    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HELD: begin
        if (!pressed) begin
          state_d = RELEASE_DB;
          cnt_d   = '0;
        end
      end
      RELEASE_DB: begin
        if (pressed) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d     = RELEASED;
          cnt_d       = '0;
          key_level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d     = RELEASED;
        cnt_d       = '0;
        key_level_d = 1'b0;
      end
    endcase
  end

`ifdef TAP_AUTO_REPEAT_EN
  // Being outside HELD keeps the counter at zero, so entry into HELD starts from zero.
  always_comb begin
    rpt_d     = rpt_q;
    rpt_event = 1'b0;
    if (state_q != HELD) begin
      rpt_d = '0;
    end else if (bus.game_tick) begin
      if (rpt_q == RPT_LAST) begin
        rpt_d     = '0;
        rpt_event = 1'b1;
      end else begin
        rpt_d = rpt_q + RPT_W'(1);
      end
    end
  end

  always_comb press_event = db_event | rpt_event;
`else
  always_comb press_event = db_event;
`endif

  // A tick hands the pending press to tap and captures a same-edge event as the
  // next pending one, so nothing is lost on a tick edge.
  always_comb begin
    tap_d     = tap_q;
    pending_d = pending_q;
    dropped_d = 1'b0;
    if (bus.game_tick) begin
      tap_d     = pending_q;
      pending_d = press_event;
    end else begin
      pending_d = pending_q | press_event;
      dropped_d = press_event & pending_q;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= SYNC_IDLE;
      sync2_q     <= SYNC_IDLE;
      state_q     <= RELEASED;
      cnt_q       <= '0;
      key_level_q <= 1'b0;
      pending_q   <= 1'b0;
      tap_q       <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_level_q <= key_level_d;
      pending_q   <= pending_d;
      tap_q       <= tap_d;
      dropped_q   <= dropped_d;
    end
  end

`ifdef TAP_AUTO_REPEAT_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rpt_q <= '0;
    end else begin
      rpt_q <= rpt_d;
    end
  end
`endif

  assign bus.tap         = tap_q;
  assign bus.key_level   = key_level_q;
  assign bus.tap_dropped = dropped_q;

endmodule

// File: tb/tb_tap_pulse_generator.sv
// Directed bench for tap_pulse_generator with DEBOUNCE_CYCLES=4, active-low key.
module tb_tap_pulse_generator;

`ifdef TAP_AUTO_REPEAT_EN
  localparam bit AUTO_REP = 1'b1;
`else
  localparam bit AUTO_REP = 1'b0;
`endif

  logic clock;
  logic resetn;
  int   n_checks;
  int   n_fail;

  tap_pulse_generator_if bus ();

  tap_pulse_generator #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W(3),
    .KEY_ACTIVE_LOW(1'b1)
`ifdef TAP_AUTO_REPEAT_EN
    , .REPEAT_TICKS(3)
`endif
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .bus(bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic cyc(input logic tk);
    bus.game_tick = tk;
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    bus.key_in    = 1'b1;
    bus.game_tick = 1'b0;
    resetn        = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1'b0);
  endtask

  task automatic test_reset();
    resetn        = 1'b1;
    bus.key_in    = 1'b1;
    bus.game_tick = 1'b0;
    #2;
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.tap !== 1'b0) begin n_fail++; $display("FAIL reset_tap got=%b exp=0", bus.tap); end
    n_checks++;
    if (bus.key_level !== 1'b0) begin n_fail++; $display("FAIL reset_key_level got=%b exp=0", bus.key_level); end
    n_checks++;
    if (bus.tap_dropped !== 1'b0) begin n_fail++; $display("FAIL reset_dropped got=%b exp=0", bus.tap_dropped); end
    n_checks++;
    if (dut.pending_q !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", dut.pending_q); end
    cyc(1'b0);
    cyc(1'b0);
    resetn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc((i % 4) == 3);
      n_checks++;
      if (bus.tap !== 1'b0 || bus.key_level !== 1'b0 || bus.tap_dropped !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle i=%0d tap=%b lvl=%b drop=%b exp=000", i, bus.tap, bus.key_level, bus.tap_dropped);
      end
    end
  endtask

  task automatic test_debounce_accept();
    logic e_tap, e_lvl;
    apply_reset();
    for (int i = 0; i < 60; i++) begin
      bus.key_in = (i < 40) ? 1'b0 : 1'b1;
      cyc((i % 10) == 9);
      e_lvl = (i >= 6 && i <= 45);
      e_tap = (i >= 9 && i <= 18) || (AUTO_REP && i >= 39 && i <= 48);
      n_checks++;
      if (bus.key_level !== e_lvl) begin n_fail++; $display("FAIL accept_key_level i=%0d got=%b exp=%b", i, bus.key_level, e_lvl); end
      n_checks++;
      if (bus.tap !== e_tap) begin n_fail++; $display("FAIL accept_tap i=%0d got=%b exp=%b", i, bus.tap, e_tap); end
      n_checks++;
      if (bus.tap_dropped !== 1'b0) begin n_fail++; $display("FAIL accept_dropped i=%0d got=%b exp=0", i, bus.tap_dropped); end
    end
  endtask

  task automatic test_glitch_reject();
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      bus.key_in = (i <= 2) ? 1'b0 : 1'b1;
      cyc((i % 10) == 9);
      n_checks++;
      if (bus.key_level !== 1'b0 || bus.tap !== 1'b0 || bus.tap_dropped !== 1'b0) begin
        n_fail++;
        $display("FAIL glitch i=%0d lvl=%b tap=%b drop=%b exp=000", i, bus.key_level, bus.tap, bus.tap_dropped);
      end
    end
  endtask

  task automatic test_coalesce();
    logic e_tap, e_lvl, e_drop;
    apply_reset();
    for (int i = 0; i < 210; i++) begin
      bus.key_in = (i <= 14 || (i >= 30 && i <= 44)) ? 1'b0 : 1'b1;
      cyc(i == 99 || i == 199);
      e_lvl  = (i >= 6 && i <= 20) || (i >= 36 && i <= 50);
      e_tap  = (i >= 99 && i <= 198);
      e_drop = (i == 36);
      n_checks++;
      if (bus.key_level !== e_lvl) begin n_fail++; $display("FAIL coalesce_key_level i=%0d got=%b exp=%b", i, bus.key_level, e_lvl); end
      n_checks++;
      if (bus.tap !== e_tap) begin n_fail++; $display("FAIL coalesce_tap i=%0d got=%b exp=%b", i, bus.tap, e_tap); end
      n_checks++;
      if (bus.tap_dropped !== e_drop) begin n_fail++; $display("FAIL coalesce_dropped i=%0d got=%b exp=%b", i, bus.tap_dropped, e_drop); end
    end
  endtask

  task automatic test_simultaneous();
    logic e_tap;
    apply_reset();
    for (int i = 0; i < 70; i++) begin
      bus.key_in = (i <= 14 || (i >= 30 && i <= 44)) ? 1'b0 : 1'b1;
      cyc(i >= 36 && ((i - 36) % 10) == 0);
      e_tap = (i >= 36 && i <= 55);
      n_checks++;
      if (bus.tap !== e_tap) begin n_fail++; $display("FAIL simul_tap i=%0d got=%b exp=%b", i, bus.tap, e_tap); end
      n_checks++;
      if (bus.tap_dropped !== 1'b0) begin n_fail++; $display("FAIL simul_dropped i=%0d got=%b exp=0", i, bus.tap_dropped); end
      if (i == 35 || i == 36 || i == 46) begin
        n_checks++;
        if (dut.pending_q !== (i != 46)) begin
          n_fail++;
          $display("FAIL simul_pending i=%0d got=%b exp=%b", i, dut.pending_q, (i != 46));
        end
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    logic e_lvl;
    apply_reset();
    for (int i = 0; i < 45; i++) begin
      bus.key_in = (i <= 14 || i >= 30) ? 1'b0 : 1'b1;
      cyc(i == 8);
    end
    n_checks++;
    if (bus.tap !== 1'b1 || dut.pending_q !== 1'b1 || bus.key_level !== 1'b1) begin
      n_fail++;
      $display("FAIL midhold_pre tap=%b pend=%b lvl=%b exp=111", bus.tap, dut.pending_q, bus.key_level);
    end
    resetn = 1'b0;
    #1;
    n_checks++;
    if (bus.tap !== 1'b0 || dut.pending_q !== 1'b0 || bus.key_level !== 1'b0 || bus.tap_dropped !== 1'b0) begin
      n_fail++;
      $display("FAIL midhold_async tap=%b pend=%b lvl=%b drop=%b exp=0000", bus.tap, dut.pending_q, bus.key_level, bus.tap_dropped);
    end
    @(posedge clock); #1;
    @(posedge clock); #1;
    resetn = 1'b1;
    for (int j = 0; j < 10; j++) begin
      cyc(1'b0);
      e_lvl = (j >= 6);
      n_checks++;
      if (bus.key_level !== e_lvl) begin n_fail++; $display("FAIL midhold_key_level j=%0d got=%b exp=%b", j, bus.key_level, e_lvl); end
      n_checks++;
      if (bus.tap !== 1'b0) begin n_fail++; $display("FAIL midhold_tap j=%0d got=%b exp=0", j, bus.tap); end
    end
    n_checks++;
    if (dut.pending_q !== 1'b1) begin n_fail++; $display("FAIL midhold_repending got=%b exp=1", dut.pending_q); end
    bus.key_in = 1'b1;
  endtask

`ifdef TAP_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    logic e_tap, e_lvl;
    apply_reset();
    for (int i = 0; i < 160; i++) begin
      bus.key_in = (i < 130) ? 1'b0 : 1'b1;
      cyc((i % 10) == 9);
      e_tap = (i >= 9 && i <= 138) && (((i - 9) % 30) < 10);
      e_lvl = (i >= 6 && i <= 135);
      n_checks++;
      if (bus.tap !== e_tap) begin n_fail++; $display("FAIL repeat_tap i=%0d got=%b exp=%b", i, bus.tap, e_tap); end
      n_checks++;
      if (bus.key_level !== e_lvl) begin n_fail++; $display("FAIL repeat_key_level i=%0d got=%b exp=%b", i, bus.key_level, e_lvl); end
      n_checks++;
      if (bus.tap_dropped !== 1'b0) begin n_fail++; $display("FAIL repeat_dropped i=%0d got=%b exp=0", i, bus.tap_dropped); end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_debounce_accept();
    test_glitch_reject();
    test_coalesce();
    test_simultaneous();
    test_reset_mid_hold();
`ifdef TAP_AUTO_REPEAT_EN
    test_auto_repeat();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tap_pulse_generator.md
Name: tap_pulse_generator

Overview:
- Producer side of the character's tap interface.
- Converts the raw player push-button into a clean, debounced press event.
- Delivers each press as a `tap` pulse exactly one game-tick period wide, so the character register, clocked on the game tick, samples each press exactly once.
- Sits between the board key input and the character register; runs on the fast system clock and receives the game tick as a one-cycle strobe.

Parameters:
- DEBOUNCE_CYCLES, 1000000: clock cycles the key must be stable before a press or release is accepted (20 ms at 50 MHz).
- CNT_W, 20: debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.
- KEY_ACTIVE_LOW, 1: 1 = key_in low means pressed; 0 = high means pressed.
- REPEAT_TICKS, 8: game ticks between auto-repeat events; used only with AUTO_REPEAT_EN.

Ports:
- clock  input  1  system clock; all state updates on its rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- key_in  input  1  raw, unsynchronised push-button.
- game_tick  input  1  one-clock strobe marking each game tick.
- tap  output  1  press pulse; changes only on game_tick cycles; high for exactly one game-tick period per accepted press.
- key_level  output  1  debounced key level (1 = held).
- tap_dropped  output  1  one-clock pulse when a press is coalesced into an already-pending tap.

Behaviour:
- Reset (async, resetn low):
  - tap=0, key_level=0, tap_dropped=0, pending=0.
  - FSM=RELEASED, debounce counter=0, repeat counter=0.
  - Both synchroniser flops reset to the not-pressed level.
- Synchroniser: two flops on key_in; "pressed" is taken from the second flop after KEY_ACTIVE_LOW polarity.
- FSM states: RELEASED, PRESS_DB, HELD, RELEASE_DB.
  - RELEASED: pressed -> PRESS_DB, counter=0.
  - PRESS_DB: not pressed -> RELEASED (glitch rejected, no event). Otherwise counter increments. At counter==DEBOUNCE_CYCLES-1 -> HELD, key_level<=1, and a press event is raised on that edge.
  - HELD: not pressed -> RELEASE_DB, counter=0.
  - RELEASE_DB: pressed -> HELD (no new event). At counter==DEBOUNCE_CYCLES-1 with key still released -> RELEASED, key_level<=0.
- Latency: with a clean press, the press event occurs on edge 3+DEBOUNCE_CYCLES after the first edge sampling key_in pressed.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around.
- Pending/tap logic, on each edge:
  - game_tick=1: tap<=pending; pending<=press_event.
  - game_tick=0: tap holds; pending<=pending|press_event.
  - press_event with pending already 1 and game_tick=0: pending stays 1, tap_dropped=1 for one cycle.
  - press_event on a game_tick cycle: current pending goes to tap; the new event becomes pending. Nothing is dropped.
- Consequences:
  - At most one tap per game-tick period; never two consecutive tap-high periods from one press.
  - tap is always 0 before the first game_tick after reset.
- Reset mid-operation: all outputs clear immediately (async). A key held through reset release must re-debounce before producing an event.

Optional Feature:
- Macro: TAP_AUTO_REPEAT_EN.
- Defined: while in HELD, a repeat counter increments on each game_tick. When it reaches REPEAT_TICKS-1 it clears and raises a press event, using the same pending rules. The counter clears on entry to HELD and in any other state.
- Undefined: exactly one press event per debounced press; the repeat counter and REPEAT_TICKS are absent from the logic.

Test Plan:
1. Debounce accept: DEBOUNCE_CYCLES=4, game_tick every 10 clocks, clean press held 40 clocks.
   - key_level rises 7 edges after key_in asserts.
   - tap high for exactly one 10-clock period starting at the next game_tick.
   - tap_dropped stays 0.
2. Glitch reject: DEBOUNCE_CYCLES=4, key_in pressed for 3 clocks, then released.
   - key_level, tap and tap_dropped stay 0 for 50 clocks.
3. Coalescing: two clean press/release cycles completed within one 100-clock tick gap, DEBOUNCE_CYCLES=4.
   - Exactly one tap period.
   - One tap_dropped pulse at the second press event.
4. Simultaneous: press event on the same edge as game_tick while pending=1.
   - tap=1 for that tick period, pending remains 1.
   - tap=1 again for the following period; tap_dropped=0.
5. Reset mid-hold: resetn low for 2 clocks while in HELD with pending=1.
   - tap, key_level and pending are 0 immediately.
   - After release with the key still held, key_level returns only after 3+4 edges.
6. TAP_AUTO_REPEAT_EN, REPEAT_TICKS=3: key held for 12 ticks.
   - Taps at the first tick after the press event, then every 3rd tick thereafter.
